mem_access_unit: RTL and testbench

//  MIPS MEM-stage data-memory unit with byte/halfword/word loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW).

---
 rtl/mem_access_pkg.sv | 61 ++++++
 rtl/mem_datos_be.sv | 46 ++++
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and lane helpers for the MEM-stage data-memory unit.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam int MEM_RD  = 0;
    localparam int MEM_WR  = 1;
    localparam int MEM_UNS = 2;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        DUMP_IDLE,
        DUMP_FETCH,
        DUMP_SEND,
        DUMP_DONE
    } dump_state_t;

    // Offset must already be aligned to the access size.
    function automatic logic [LANES-1:0] lane_enable(input logic [1:0] size,
                                                     input logic [1:0] offset);
        logic [LANES-1:0] enable;
        case (size)
            SZ_BYTE: enable = 4'b0001 << offset;
            SZ_HALF: enable = offset[1] ? 4'b1100 : 4'b0011;
            default: enable = 4'b1111;
        endcase
        return enable;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size,
                                                input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{data[7:0]}};
            SZ_HALF: lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  offset,
                                                input logic        is_unsigned);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_BYTE: result = is_unsigned ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: result = is_unsigned ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_datos_be.sv
// Byte-enabled data RAM with a registered pipeline read port and a registered dump read port.
module mem_datos_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    read_en,
    output logic [DATA_WIDTH-1:0]   rdata,
    input  logic [ADDR_WIDTH-1:0]   dump_addr,
    input  logic                    dump_read_en,
    output logic [DATA_WIDTH-1:0]   dump_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array contents survive reset; only the read registers are cleared.
    always_ff @(posedge clock) begin
        for (int lane = 0; lane < LANES; lane++) begin
            if (byte_en[lane]) begin
                mem[addr][lane*8 +: 8] <= wdata[lane*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata      <= '0;
            dump_rdata <= '0;
        end else begin
            if (read_en) begin
                rdata <= mem[addr];
            end
            if (dump_read_en) begin
                dump_rdata <= mem[dump_addr];
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS MEM-stage unit: byte/half/word loads and stores plus a debug memory dump sequencer.
// Define MEM_MISALIGN_TRAP_EN to flag and suppress misaligned accesses instead of aligning them.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_aluresult,
    input  logic [DATA_WIDTH-1:0] i_regB,
    input  logic [2:0]            i_mem,
    input  logic [1:0]            i_size,
    output logic [DATA_WIDTH-1:0] o_dataread,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic                  o_misaligned,
    input  logic                  i_dbg_start,
    input  logic                  i_dbg_ready,
    output logic                  o_dbg_valid,
    output logic [DATA_WIDTH-1:0] o_dbg_data,
    output logic [ADDR_WIDTH-1:0] o_dbg_addr,
    output logic                  o_dbg_done,
    output logic                  o_busy
);

    logic [1:0]            raw_offset;
    logic [1:0]            offset;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] word_index;
    logic                  is_half;
    logic                  is_word;
    logic                  misaligned;
    logic                  load;
    logic                  store;
    logic                  busy;
    logic [LANES-1:0]      byte_en;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic [1:0]            load_size;
    logic [1:0]            load_offset;
    logic                  load_unsigned;
    logic                  load_zero;
    logic [DATA_WIDTH-1:0] address;
    logic                  misaligned_flag;

    dump_state_t           state;
    dump_state_t           state_next;
    logic [ADDR_WIDTH-1:0] pointer;
    logic [ADDR_WIDTH-1:0] pointer_next;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [ADDR_WIDTH-1:0] dbg_addr_next;
    logic                  dump_read_en;

    assign raw_offset = i_aluresult[1:0];
    assign word_index = i_aluresult[ADDR_WIDTH+1:2];
    assign is_half    = (i_size == SZ_HALF);
    assign is_word    = i_size[1];
    assign size       = is_word ? SZ_WORD : i_size;
    assign offset     = is_word ? 2'b00 : (is_half ? {raw_offset[1], 1'b0} : raw_offset);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = (is_half && raw_offset[0]) || (is_word && (raw_offset != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // A read paired with a write is a write; stores are frozen while the dump owns the RAM.
    assign busy    = (state != DUMP_IDLE);
    assign load    = i_mem[MEM_RD] && !i_mem[MEM_WR];
    assign store   = i_mem[MEM_WR] && !busy;
    assign byte_en = (store && !misaligned) ? lane_enable(size, offset) : '0;

    mem_datos_be #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clock       (i_clock),
        .reset       (i_reset),
        .addr        (word_index),
        .byte_en     (byte_en),
        .wdata       (store_lanes(size, i_regB)),
        .read_en     (load),
        .rdata       (ram_rdata),
        .dump_addr   (pointer),
        .dump_read_en(dump_read_en),
        .dump_rdata  (o_dbg_data)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            load_size       <= SZ_BYTE;
            load_offset     <= 2'b00;
            load_unsigned   <= 1'b0;
            load_zero       <= 1'b0;
            address         <= '0;
            misaligned_flag <= 1'b0;
        end else begin
            if (load) begin
                load_size     <= size;
                load_offset   <= offset;
                load_unsigned <= i_mem[MEM_UNS];
                load_zero     <= misaligned;
                address       <= i_aluresult;
            end
            misaligned_flag <= misaligned && (load || store);
        end
    end

    // Lane selection happens after the RAM register so the load word is read only once.
    assign o_dataread   = load_zero ? '0
                                    : extend_load(ram_rdata, load_size, load_offset, load_unsigned);
    assign o_address    = address;
    assign o_misaligned = misaligned_flag;
    assign o_busy       = busy;
    assign o_dbg_addr   = dbg_addr;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= DUMP_IDLE;
            pointer  <= '0;
            dbg_addr <= '0;
        end else begin
            state    <= state_next;
            pointer  <= pointer_next;
            dbg_addr <= dbg_addr_next;
        end
    end

    always_comb begin
        state_next    = state;
        pointer_next  = pointer;
        dbg_addr_next = dbg_addr;
        dump_read_en  = 1'b0;
        o_dbg_valid   = 1'b0;
        o_dbg_done    = 1'b0;
        case (state)
            DUMP_IDLE: begin
                if (i_dbg_start) begin
                    pointer_next = '0;
                    state_next   = DUMP_FETCH;
                end
            end
            DUMP_FETCH: begin
                dump_read_en  = 1'b1;
                dbg_addr_next = pointer;
                state_next    = DUMP_SEND;
            end
            DUMP_SEND: begin
                o_dbg_valid = 1'b1;
                if (i_dbg_ready) begin
                    if (&pointer) begin
                        state_next = DUMP_DONE;
                    end else begin
                        pointer_next = pointer + 1'b1;
                        state_next   = DUMP_FETCH;
                    end
                end
            end
            DUMP_DONE: begin
                o_dbg_done = 1'b1;
                state_next = DUMP_IDLE;
            end
            default: state_next = DUMP_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit against a word-array reference model; honours MEM_MISALIGN_TRAP_EN.
module tb_mem_access_unit;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clock;
    logic          reset;
    logic [31:0]   alu_result;
    logic [31:0]   reg_b;
    logic [2:0]    mem_ctrl;
    logic [1:0]    size;
    logic [31:0]   data_read;
    logic [31:0]   address;
    logic          misaligned;
    logic          dbg_start;
    logic          dbg_ready;
    logic          dbg_valid;
    logic [31:0]   dbg_data;
    logic [AW-1:0] dbg_addr;
    logic          dbg_done;
    logic          busy;

    logic [31:0] mem_model [DEPTH];
    logic [31:0] exp_data;
    logic [31:0] exp_addr;
    logic        exp_mis;
    int          check_count;
    int          pass_count;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_aluresult (alu_result),
        .i_regB      (reg_b),
        .i_mem       (mem_ctrl),
        .i_size      (size),
        .o_dataread  (data_read),
        .o_address   (address),
        .o_misaligned(misaligned),
        .i_dbg_start (dbg_start),
        .i_dbg_ready (dbg_ready),
        .o_dbg_valid (dbg_valid),
        .o_dbg_data  (dbg_data),
        .o_dbg_addr  (dbg_addr),
        .o_dbg_done  (dbg_done),
        .o_busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        else
            pass_count++;
    endtask

    function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic uns);
        logic [31:0] word;
        logic [31:0] val;
        word = mem_model[int'(a[AW+1:2])];
        if (sz == 2'b00) begin
            val = (word >> (8 * int'(a[1:0]))) & 32'hFF;
            if (!uns && val[7]) val = val | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            val = (word >> (16 * int'(a[1]))) & 32'hFFFF;
            if (!uns && val[15]) val = val | 32'hFFFF_0000;
        end else begin
            val = word;
        end
        return val;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int idx;
        idx = int'(a[AW+1:2]);
        if (sz == 2'b00)      mem_model[idx][8*int'(a[1:0]) +: 8] = d[7:0];
        else if (sz == 2'b01) mem_model[idx][16*int'(a[1]) +: 16] = d[15:0];
        else                  mem_model[idx] = d;
    endtask

    // Drives one pipeline cycle, advances the model, and returns 1 time unit after the edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic uns,
                                 input logic [1:0] sz, input logic [31:0] a,
                                 input logic [31:0] d, input logic blocked);
        logic mis;
        alu_result = a;
        reg_b      = d;
        mem_ctrl   = {uns, wr, rd};
        size       = sz;
        mis        = model_misaligned(sz, a);
        exp_mis    = 1'b0;
        if (wr) begin
            if (!blocked) begin
                if (mis) exp_mis = 1'b1;
                else     model_store(a, sz, d);
            end
        end else if (rd) begin
            exp_addr = a;
            exp_data = mis ? 32'h0 : model_load(a, sz, uns);
            exp_mis  = mis;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idleCycle(input logic blocked);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, blocked);
    endtask

    task automatic checkPipe(input string tag);
        checkOutput({tag, "_data"}, data_read, exp_data);
        checkOutput({tag, "_addr"}, address, exp_addr);
        checkOutput({tag, "_mis"}, {31'b0, misaligned}, {31'b0, exp_mis});
    endtask

    task automatic runDump(input bit inject_store);
        int  accepted;
        bit  prev_accept;
        bit  prev_wait;
        bit  injected;
        bit  finished;
        accepted    = 0;
        prev_accept = 0;
        prev_wait   = 0;
        injected    = 0;
        finished    = 0;
        dbg_start   = 1'b1;
        idleCycle(1'b0);
        dbg_start   = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            checkOutput("dump_busy", {31'b0, busy}, 32'd1);
            if (accepted == DEPTH) begin
                checkOutput("dump_done", {31'b0, dbg_done}, 32'd1);
                checkOutput("dump_valid_in_done", {31'b0, dbg_valid}, 32'd0);
                dbg_ready = 1'b0;
                idleCycle(1'b1);
                checkOutput("dump_done_pulse", {31'b0, dbg_done}, 32'd0);
                checkOutput("dump_busy_end", {31'b0, busy}, 32'd0);
                finished = 1;
            end else begin
                checkOutput("dump_done_early", {31'b0, dbg_done}, 32'd0);
                if (prev_accept) checkOutput("dump_fetch_gap", {31'b0, dbg_valid}, 32'd0);
                if (prev_wait)   checkOutput("dump_hold_valid", {31'b0, dbg_valid}, 32'd1);
                prev_accept = 0;
                prev_wait   = 0;
                dbg_ready   = cyc[0];
                if (dbg_valid) begin
                    checkOutput("dump_data", dbg_data, mem_model[accepted]);
                    checkOutput("dump_addr", {28'b0, dbg_addr}, accepted);
                    if (dbg_ready) begin
                        accepted++;
                        prev_accept = 1;
                    end else begin
                        prev_wait = 1;
                    end
                end
                if (inject_store && !injected && dbg_valid) begin
                    injected = 1;
                    applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, (DEPTH - 1) * 4,
                                  ~mem_model[DEPTH-1], 1'b1);
                end else begin
                    idleCycle(1'b1);
                end
            end
        end
        if (!finished) checkOutput("dump_timeout", 32'd0, 32'd1);
        dbg_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] val;
        int          op;
        check_count = 0;
        pass_count  = 0;
        reset       = 1'b1;
        alu_result  = '0;
        reg_b       = '0;
        mem_ctrl    = '0;
        size        = '0;
        dbg_start   = 1'b0;
        dbg_ready   = 1'b0;
        exp_data    = '0;
        exp_addr    = '0;
        exp_mis     = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        checkPipe("reset");
        checkOutput("reset_dbg_valid", {31'b0, dbg_valid}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, dbg_done}, 32'd0);
        checkOutput("reset_dbg_data", dbg_data, 32'd0);
        checkOutput("reset_dbg_addr", {28'b0, dbg_addr}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, i * 4, $urandom, 1'b0);

        // Directed lane and extension cases around word 0x10.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 32'h10, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 32'h10, 32'h0, 1'b0);
        checkPipe("lw");
        checkOutput("lw_const", data_read, 32'hDEADBEEF);
        checkOutput("lw_addr_const", address, 32'h10);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'h13, 32'h0, 1'b0);
        checkOutput("lb_const", data_read, 32'hFFFFFFDE);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 32'h13, 32'h0, 1'b0);
        checkOutput("lbu_const", data_read, 32'h000000DE);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b01, 32'h12, 32'h0, 1'b0);
        checkOutput("lh_const", data_read, 32'hFFFFDEAD);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 32'h10, 32'h0, 1'b0);
        checkOutput("lhu_const", data_read, 32'h0000BEEF);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 32'h11, 32'hAAAA_AA55, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 32'h10, 32'h0, 1'b0);
        checkOutput("sb_const", data_read, 32'hDEAD55EF);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 32'h12, 32'hBBBB_1234, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 32'h10, 32'h0, 1'b0);
        checkOutput("sh_const", data_read, 32'h123455EF);
        checkPipe("sh_lw");

        idleCycle(1'b0);
        checkPipe("hold");
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 32'h20, 32'h0BAD_F00D, 1'b0);
        checkPipe("rdwr");
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 32'h20, 32'h0, 1'b0);
        checkPipe("rdwr_lw");

        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 32'h12, 32'hCAFE_F00D, 1'b0);
        checkPipe("sw_mis");
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 32'h10, 32'h0, 1'b0);
        checkPipe("sw_mis_lw");
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 32'h12, 32'h0, 1'b0);
        checkPipe("lw_mis");
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b01, 32'h11, 32'h0, 1'b0);
        checkPipe("lh_mis");
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 32'h10 + DEPTH * 4, 32'h7777_0001, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 32'h10, 32'h0, 1'b0);
        checkPipe("wrap");

        for (int n = 0; n < 400; n++) begin
            op  = $urandom_range(0, 3);
            val = $urandom;
            applyStimulus(op == 1 || op == 3, op >= 2, 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), $urandom, val, 1'b0);
            checkPipe("rand");
        end

        runDump(1'b1);
        idleCycle(1'b0);
        checkPipe("after_dump");

        // Reset while a word is being offered.
        dbg_start = 1'b1;
        idleCycle(1'b0);
        dbg_start = 1'b0;
        dbg_ready = 1'b0;
        for (int n = 0; n < 10 && !dbg_valid; n++) idleCycle(1'b1);
        checkOutput("pre_reset_valid", {31'b0, dbg_valid}, 32'd1);
        reset = 1'b1;
        idleCycle(1'b0);
        exp_data = '0;
        exp_addr = '0;
        exp_mis  = 1'b0;
        checkOutput("mid_reset_valid", {31'b0, dbg_valid}, 32'd0);
        checkOutput("mid_reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("mid_reset_dbg_data", dbg_data, 32'd0);
        checkPipe("mid_reset");
        reset = 1'b0;
        runDump(1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
